gcd_scheduler: RTL

//  Shares one GCD engine among NREQ requesters. Round-robin arbiter grants one request, latches its operands,

---
 rtl/gcd_scheduler.sv | 122 ++++++++++++
 1 files changed

// File: rtl/gcd_scheduler.sv
// gcd_scheduler: round-robin scheduler sharing one GCD engine among NREQ requesters
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_req_valid/i_req_a/i_req_b     per-requester request, operand slice i = [8i+7:8i]
//   o_req_ready                     one-hot grant, combinational, only while idle
//   o_rsp_valid/i_rsp_ready         response handshake
//   o_rsp_id/o_rsp_y                served requester and its GCD (0 on error)
//   o_rsp_error/o_rsp_timeout       engine error or watchdog abort (timeout implies error)
//   o_gcd_start/o_gcd_a/o_gcd_b     engine start pulse and operands held from grant until response
//   i_gcd_y/i_gcd_done/i_gcd_error  engine result, sampled only on done while waiting
//   o_busy                          any job in flight
module gcd_scheduler #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 300
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [8*NREQ-1:0] i_req_a,
    input  logic [8*NREQ-1:0] i_req_b,
    output logic [NREQ-1:0]   o_req_ready,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [IDW-1:0]    o_rsp_id,
    output logic [7:0]        o_rsp_y,
    output logic              o_rsp_error,
    output logic              o_rsp_timeout,
    output logic              o_gcd_start,
    output logic [7:0]        o_gcd_a,
    output logic [7:0]        o_gcd_b,
    input  logic [7:0]        i_gcd_y,
    input  logic              i_gcd_done,
    input  logic              i_gcd_error,
    output logic              o_busy
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         r_state, w_next;
    logic [IDW-1:0] r_ptr, r_tag, w_gnt, w_ptr_nxt;
    logic [IDW:0]   w_sum;
    logic [CW-1:0]  r_cnt;
    logic [7:0]     r_a, r_b, r_y;
    logic           r_err, r_to, w_grant, w_to_hit;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_gnt = '0;
        w_sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (IDW + 1)'(k);
            w_sum = (w_sum >= (IDW + 1)'(NREQ)) ? w_sum - (IDW + 1)'(NREQ) : w_sum;
            if (i_req_valid[w_sum[IDW-1:0]]) w_gnt = w_sum[IDW-1:0];
        end
    end

    assign w_grant   = (r_state == IDLE) && |i_req_valid;
    assign w_ptr_nxt = (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
    assign w_to_hit  = r_cnt == CW'(TIMEOUT - 1);

    // Ready is gated by reset so no grant is advertised while the block is held in reset.
    assign o_req_ready   = (w_grant && i_rst_n) ? NREQ'(1) << w_gnt : '0;
    assign o_rsp_valid   = r_state == RESP;
    assign o_gcd_start   = r_state == ISSUE;
    assign o_busy        = r_state != IDLE;
    assign o_gcd_a       = r_a;
    assign o_gcd_b       = r_b;
    assign o_rsp_id      = r_tag;
    assign o_rsp_y       = r_y;
    assign o_rsp_error   = r_err;
    assign o_rsp_timeout = r_to;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_grant ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = (i_gcd_done || w_to_hit) ? RESP : WAIT;
            RESP:    w_next = i_rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
            r_tag <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_y   <= '0;
            r_err <= 1'b0;
            r_to  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_a   <= i_req_a[{w_gnt, 3'b000} +: 8];
                r_b   <= i_req_b[{w_gnt, 3'b000} +: 8];
                r_tag <= w_gnt;
                r_ptr <= w_ptr_nxt;
            end
            if (r_state == ISSUE) r_cnt <= '0;
            else if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
            // Done takes priority over the watchdog when both land in the same cycle.
            if (r_state == WAIT && i_gcd_done) begin
                r_y   <= i_gcd_error ? 8'd0 : i_gcd_y;
                r_err <= i_gcd_error;
                r_to  <= 1'b0;
            end else if (r_state == WAIT && w_to_hit) begin
                r_y   <= 8'd0;
                r_err <= 1'b1;
                r_to  <= 1'b1;
            end
        end
    end
endmodule
